heap_alloc: RTL and testbench
=============================

# heap_alloc

Parametrised linked-memory heap allocator, the successor to the fixed 16-bit allocator. It manages a BRAM-backed cell heap with a LIFO free-list threaded through freed cells, plus a read/write access port. New in this generation: parameterised width, depth and heap base tag, asynchronous reset, a sticky coded error, an optional allocation bitmap for double-free and stale-access detection, and occupancy outputs. It sits between the core's evaluator/GC logic and the heap BRAM.

## Interface
- DATA_SZ, 16: bits per word and per address value.
- ADDR_SZ, 8: index bits; heap holds 2^ADDR_SZ cells.
- BASE_TAG, 16'h5000: upper-bit tag ORed onto every issued address (DATA_SZ-1 downto ADDR_SZ).
- CHECK_ALLOC, 1: when 1, instantiate the allocation bitmap and its checks.
- i_clk  in  1  domain clock
- i_rst  in  1  reset, asynchronous, active-high
- i_al  in  1  allocate request
- i_adata  in  DATA_SZ  initial data for new cell
- o_aaddr  out  DATA_SZ  allocated address (UNDEF when none)
- i_fr  in  1  free request
- i_faddr  in  DATA_SZ  address to free
- i_wr  in  1  write request
- i_waddr  in  DATA_SZ  write address
- i_wdata  in  DATA_SZ  write data
- i_rd  in  1  read request
- i_raddr  in  DATA_SZ  read address
- o_rdata  out  DATA_SZ  read data (UNDEF when no read last cycle)
- o_free_cnt  out  ADDR_SZ+1  cells on free-list
- o_top  out  ADDR_SZ+1  high-water index (cells ever issued)
- o_err  out  1  sticky error
- o_err_code  out  3  0 none, 1 port conflict, 2 out of memory, 3 address out of range, 4 unallocated/double free

## Operation
- Address valid iff upper bits equal BASE_TAG upper bits and index < top.
- Ptr port (al/fr) and mem port (rd/wr) are mutually exclusive per cycle; both active sets code 1.
- Alloc only: if free_cnt != 0, pop the head: issue head, write i_adata there, read its link; free_cnt-1. Otherwise issue BASE_TAG|top and top+1; top == 2^ADDR_SZ sets code 2.
- Free only: write current head into cell i_faddr, head := i_faddr, free_cnt+1.
- Alloc+free same cycle: o_aaddr := i_faddr, write i_adata there; free-list, counts and bitmap unchanged.
- Head is NIL (16'h0001) when the list is empty; head bypass: if the previous cycle popped, head = BRAM rdata this cycle (back-to-back pops every cycle).
- Read/write: plain BRAM access at the index.
- Checks, in priority order 1 > 3 > 4 > 2: range check on i_faddr, i_raddr and i_waddr. With CHECK_ALLOC, free/rd/wr of a cell whose bitmap bit is 0 sets code 4. Alloc sets the bit; free clears it.
- On any error: the offending op has no effect, o_err=1, and o_err_code latches the code. All later requests are ignored and outputs hold UNDEF until i_rst.

## Timing
- All results one cycle after request: o_aaddr, o_rdata, o_err, counts. Full throughput, one request per cycle.
- o_aaddr = UNDEF the cycle after any non-alloc cycle. o_rdata = UNDEF unless a read was accepted last cycle.
- Write-then-read of the same address on consecutive cycles returns the new data (BRAM write-first is not required; the read is a cycle later).
- Reset values: o_aaddr=0, o_rdata=0, o_free_cnt=0, o_top=0, o_err=0, o_err_code=0, head=NIL, bitmap all 0.
- Reset mid-operation: state clears immediately. BRAM contents are not cleared but are unreachable, since top=0.

## Structure
- Shared include heap_defs.vh: UNDEF, NIL, TRUE, FALSE, UNIT, ZERO, the tag constants DIR/MUT/OPQ/VLT, and the ERR_* codes.
- One sub-module: the existing parameterised bram (DATA_SZ, ADDR_SZ), single write and single read port with registered read.
- The bitmap is a reg vector inside heap_alloc, generated only when CHECK_ALLOC=1.

## Test plan
- Reset, then 3 allocs with data 0x8001..0x8003 -> o_aaddr 0x5000, 0x5001, 0x5002; o_top=3; reading 0x5001 -> 0x8002.
- Free 0x5001, free 0x5000, then 3 allocs -> 0x5000, 0x5001, 0x5003 (LIFO, then top); o_free_cnt 2,1,0 across the allocs.
- Alloc+free of 0x5002 in the same cycle -> o_aaddr 0x5002; o_free_cnt and o_top unchanged.
- ADDR_SZ=2: 4 allocs succeed, 5th -> o_err=1, code 2. A following read -> o_rdata UNDEF. Assert i_rst -> all outputs 0 and allocation resumes at 0x5000.
- Free 0x5000 twice -> second free gives code 4. Read of 0x6000 -> code 3. i_al with i_rd -> code 1.
- Continuous alternating free/alloc at full rate for 256 cycles -> every issued address is unique among live cells, o_free_cnt never negative, no error.

Source files
------------

// File: rtl/heap_alloc_pkg.sv
// Shared constants for the linked-memory heap: reserved word values, heap tags
// and the coded error values reported by heap_alloc.
package heap_alloc_pkg;

  // Reserved 16-bit word values; heap cells are always issued with a heap tag,
  // so none of these can collide with an issued address.
  localparam logic [15:0] ZERO  = 16'h0000;
  localparam logic [15:0] NIL   = 16'h0001;
  localparam logic [15:0] UNDEF = 16'h0002;
  localparam logic [15:0] TRUE  = 16'h0003;
  localparam logic [15:0] FALSE = 16'h0004;
  localparam logic [15:0] UNIT  = 16'h0005;

  // Upper-nibble object tags; MUT is the default heap base tag (16'h5000).
  localparam logic [3:0] DIR = 4'h4;
  localparam logic [3:0] MUT = 4'h5;
  localparam logic [3:0] OPQ = 4'h6;
  localparam logic [3:0] VLT = 4'h7;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_CONFLICT = 3'd1,
    ERR_OOM      = 3'd2,
    ERR_RANGE    = 3'd3,
    ERR_UNALLOC  = 3'd4
  } err_code_e;

endpackage

// File: rtl/heap_alloc_bram.sv
// Simple dual-port cell memory: one write port, one registered read port.
// A read and a write to the same index in one cycle return the old contents.
module heap_alloc_bram #(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_SZ-1:0] waddr,
  input  logic [DATA_SZ-1:0] wdata,
  input  logic               re,
  input  logic [ADDR_SZ-1:0] raddr,
  output logic [DATA_SZ-1:0] rdata
);

  logic [DATA_SZ-1:0] mem [2**ADDR_SZ];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/heap_alloc.sv
// Heap cell allocator: LIFO free-list threaded through freed cells, bump
// allocation from a high-water mark, read/write port and sticky error checks.
module heap_alloc
  import heap_alloc_pkg::*;
#(
  parameter int                 DATA_SZ     = 16,
  parameter int                 ADDR_SZ     = 8,
  parameter logic [DATA_SZ-1:0] BASE_TAG    = 16'h5000,
  parameter bit                 CHECK_ALLOC = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_al,
  input  logic [DATA_SZ-1:0] i_adata,
  output logic [DATA_SZ-1:0] o_aaddr,
  input  logic               i_fr,
  input  logic [DATA_SZ-1:0] i_faddr,
  input  logic               i_wr,
  input  logic [DATA_SZ-1:0] i_waddr,
  input  logic [DATA_SZ-1:0] i_wdata,
  input  logic               i_rd,
  input  logic [DATA_SZ-1:0] i_raddr,
  output logic [DATA_SZ-1:0] o_rdata,
  output logic [ADDR_SZ:0]   o_free_cnt,
  output logic [ADDR_SZ:0]   o_top,
  output logic               o_err,
  output logic [2:0]         o_err_code
);

  localparam int                 CELLS   = 1 << ADDR_SZ;
  localparam logic [ADDR_SZ:0]   FULL    = {1'b1, {ADDR_SZ{1'b0}}};
  localparam logic [DATA_SZ-1:0] UNDEF_W = DATA_SZ'(UNDEF);
  localparam logic [DATA_SZ-1:0] NIL_W   = DATA_SZ'(NIL);

  function automatic logic in_range(input logic [DATA_SZ-1:0] a, input logic [ADDR_SZ:0] top);
    return (a[DATA_SZ-1:ADDR_SZ] == BASE_TAG[DATA_SZ-1:ADDR_SZ]) && ({1'b0, a[ADDR_SZ-1:0]} < top);
  endfunction

  logic [DATA_SZ-1:0] head_q, head_n, head_eff, aaddr_q, aaddr_n;
  logic [ADDR_SZ:0]   cnt_q, cnt_n, top_q, top_n;
  logic               pop_q, pop_n, rd_q, rd_n, fresh_q, err_q;
  err_code_e          code_q, code_n;

  logic               we, re, map_set, map_clr;
  logic [ADDR_SZ-1:0] waddr, raddr, map_idx;
  logic [DATA_SZ-1:0] wdata, bram_rdata;
  logic [CELLS-1:0]   bitmap;

  logic [ADDR_SZ-1:0] fidx, ridx, widx, hidx;
  assign fidx = i_faddr[ADDR_SZ-1:0];
  assign ridx = i_raddr[ADDR_SZ-1:0];
  assign widx = i_waddr[ADDR_SZ-1:0];

  // The link of a cell popped last cycle arrives from the BRAM this cycle.
  assign head_eff = pop_q ? bram_rdata : head_q;
  assign hidx     = head_eff[ADDR_SZ-1:0];

  always_comb begin
    code_n  = ERR_NONE;
    aaddr_n = UNDEF_W;
    head_n  = head_eff;
    cnt_n   = cnt_q;
    top_n   = top_q;
    pop_n   = 1'b0;
    rd_n    = 1'b0;
    we      = 1'b0;
    waddr   = '0;
    wdata   = '0;
    re      = 1'b0;
    raddr   = '0;
    map_set = 1'b0;
    map_clr = 1'b0;
    map_idx = '0;
    if (!err_q) begin
      if ((i_al || i_fr) && (i_rd || i_wr))
        code_n = ERR_CONFLICT;
      else if ((i_fr && !in_range(i_faddr, top_q)) || (i_rd && !in_range(i_raddr, top_q)) ||
               (i_wr && !in_range(i_waddr, top_q)))
        code_n = ERR_RANGE;
      else if ((i_fr && !bitmap[fidx]) || (i_rd && !bitmap[ridx]) || (i_wr && !bitmap[widx]))
        code_n = ERR_UNALLOC;
      else if (i_al && !i_fr && cnt_q == '0 && top_q == FULL)
        code_n = ERR_OOM;
      else begin
        if (i_al && i_fr) begin
          // Freed cell is handed straight back; list and bitmap untouched.
          aaddr_n = i_faddr;
          we      = 1'b1;
          waddr   = fidx;
          wdata   = i_adata;
        end else if (i_al) begin
          we      = 1'b1;
          wdata   = i_adata;
          map_set = 1'b1;
          if (cnt_q != '0) begin
            aaddr_n = head_eff;
            waddr   = hidx;
            re      = 1'b1;
            raddr   = hidx;
            pop_n   = 1'b1;
            cnt_n   = cnt_q - 1'b1;
          end else begin
            aaddr_n = BASE_TAG | DATA_SZ'(top_q);
            waddr   = top_q[ADDR_SZ-1:0];
            top_n   = top_q + 1'b1;
          end
          map_idx = waddr;
        end else if (i_fr) begin
          we      = 1'b1;
          waddr   = fidx;
          wdata   = head_eff;
          head_n  = i_faddr;
          cnt_n   = cnt_q + 1'b1;
          map_clr = 1'b1;
          map_idx = fidx;
        end
        if (i_wr) begin
          we    = 1'b1;
          waddr = widx;
          wdata = i_wdata;
        end
        if (i_rd) begin
          re    = 1'b1;
          raddr = ridx;
          rd_n  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_q  <= NIL_W;
      pop_q   <= 1'b0;
      rd_q    <= 1'b0;
      fresh_q <= 1'b1;
      aaddr_q <= '0;
      cnt_q   <= '0;
      top_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      head_q  <= head_n;
      pop_q   <= pop_n;
      rd_q    <= rd_n;
      fresh_q <= 1'b0;
      aaddr_q <= aaddr_n;
      cnt_q   <= cnt_n;
      top_q   <= top_n;
      if (code_n != ERR_NONE) begin
        err_q  <= 1'b1;
        code_q <= code_n;
      end
    end
  end

  generate
    if (CHECK_ALLOC) begin : g_map
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) bitmap <= '0;
        else if (map_set) bitmap[map_idx] <= 1'b1;
        else if (map_clr) bitmap[map_idx] <= 1'b0;
      end
    end else begin : g_nomap
      assign bitmap = '1;
    end
  endgenerate

  heap_alloc_bram #(.DATA_SZ(DATA_SZ), .ADDR_SZ(ADDR_SZ)) u_bram (
    .clk   (i_clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (raddr),
    .rdata (bram_rdata)
  );

  // Read data is zero straight out of reset, UNDEF unless a read was accepted.
  assign o_rdata    = fresh_q ? '0 : (rd_q ? bram_rdata : UNDEF_W);
  assign o_aaddr    = aaddr_q;
  assign o_free_cnt = cnt_q;
  assign o_top      = top_q;
  assign o_err      = err_q;
  assign o_err_code = code_q;

endmodule

// File: tb/tb_heap_alloc.sv
// Directed bench for heap_alloc: a 256-cell instance for the main flows and
// error codes, and a 4-cell instance for out-of-memory and reset recovery.
module tb_heap_alloc;

  localparam logic [15:0] UNDEF = 16'h0002;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---- main instance (ADDR_SZ = 8) ----
  logic        rst = 1'b1;
  logic        al = 0, fr = 0, wr = 0, rd = 0;
  logic [15:0] adata = 0, faddr = 0, waddr = 0, wdata = 0, raddr = 0;
  logic [15:0] aaddr, rdata;
  logic [8:0]  free_cnt, top;
  logic        err;
  logic [2:0]  err_code;

  heap_alloc u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_al(al), .i_adata(adata), .o_aaddr(aaddr),
    .i_fr(fr), .i_faddr(faddr),
    .i_wr(wr), .i_waddr(waddr), .i_wdata(wdata),
    .i_rd(rd), .i_raddr(raddr), .o_rdata(rdata),
    .o_free_cnt(free_cnt), .o_top(top), .o_err(err), .o_err_code(err_code)
  );

  // ---- small instance (ADDR_SZ = 2) ----
  logic        s_rst = 1'b1;
  logic        s_al = 0, s_rd = 0;
  logic [15:0] s_adata = 0, s_raddr = 0;
  logic [15:0] s_aaddr, s_rdata;
  logic [2:0]  s_free_cnt, s_top;
  logic        s_err;
  logic [2:0]  s_err_code;

  heap_alloc #(.ADDR_SZ(2)) u_small (
    .i_clk(clk), .i_rst(s_rst),
    .i_al(s_al), .i_adata(s_adata), .o_aaddr(s_aaddr),
    .i_fr(1'b0), .i_faddr(16'h0000),
    .i_wr(1'b0), .i_waddr(16'h0000), .i_wdata(16'h0000),
    .i_rd(s_rd), .i_raddr(s_raddr), .o_rdata(s_rdata),
    .o_free_cnt(s_free_cnt), .o_top(s_top), .o_err(s_err), .o_err_code(s_err_code)
  );

  // ---- scoreboard ----
  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] live_q[$];
  logic [15:0] exp_q[$];   // model free-list, back is head
  int          model_top;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---- driver tasks: one request per cycle, outputs sampled 1ns after the edge ----
  task automatic op(input logic a, input logic [15:0] ad, input logic f, input logic [15:0] fa,
                    input logic w, input logic [15:0] wa, input logic [15:0] wd,
                    input logic r, input logic [15:0] ra);
    al = a; adata = ad; fr = f; faddr = fa; wr = w; waddr = wa; wdata = wd; rd = r; raddr = ra;
    @(posedge clk); #1;
    al = 0; fr = 0; wr = 0; rd = 0;
  endtask

  task automatic do_alloc(input logic [15:0] d);  op(1, d, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_free(input logic [15:0] a);   op(0, 0, 1, a, 0, 0, 0, 0, 0); endtask
  task automatic do_read(input logic [15:0] a);   op(0, 0, 0, 0, 0, 0, 0, 1, a); endtask
  task automatic do_write(input logic [15:0] a, input logic [15:0] d); op(0, 0, 0, 0, 1, a, d, 0, 0); endtask

  task automatic main_reset();
    rst = 1'b1;
    #1;
    check("rst_aaddr", aaddr, 16'h0000);
    check("rst_rdata", rdata, 16'h0000);
    check("rst_free_cnt", free_cnt, 0);
    check("rst_top", top, 0);
    check("rst_err", err, 0);
    check("rst_code", err_code, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic s_alloc(input logic [15:0] d);
    s_al = 1; s_adata = d;
    @(posedge clk); #1;
    s_al = 0;
  endtask

  initial begin
    @(posedge clk); #1;
    main_reset();

    // Bump allocation and a read back.
    do_alloc(16'h8001); check("al0", aaddr, 16'h5000);
    do_alloc(16'h8002); check("al1", aaddr, 16'h5001);
    do_alloc(16'h8003); check("al2", aaddr, 16'h5002);
    check("top3", top, 3);
    do_read(16'h5001);  check("rd_5001", rdata, 16'h8002);
    check("aaddr_undef_after_rd", aaddr, UNDEF);

    // LIFO reuse with back-to-back pops, then fall back to bump.
    do_free(16'h5001); check("fcnt_free1", free_cnt, 1);
    check("rdata_undef_no_rd", rdata, UNDEF);
    do_free(16'h5000); check("fcnt_free2", free_cnt, 2);
    do_alloc(16'h9001); check("reuse0", aaddr, 16'h5000); check("fcnt_a1", free_cnt, 1);
    do_alloc(16'h9002); check("reuse1", aaddr, 16'h5001); check("fcnt_a2", free_cnt, 0);
    do_alloc(16'h9003); check("bump3", aaddr, 16'h5003); check("fcnt_a3", free_cnt, 0);
    check("top4", top, 4);
    do_read(16'h5001); check("rd_reused", rdata, 16'h9002);
    do_read(16'h5000); check("rd_reused0", rdata, 16'h9001);

    // Simultaneous alloc+free hands the cell straight back.
    op(1, 16'hA5A5, 1, 16'h5002, 0, 0, 0, 0, 0);
    check("alfr_addr", aaddr, 16'h5002);
    check("alfr_fcnt", free_cnt, 0);
    check("alfr_top", top, 4);
    do_read(16'h5002); check("alfr_data", rdata, 16'hA5A5);

    // Write then read on the next cycle.
    do_write(16'h5003, 16'h1234);
    do_read(16'h5003); check("wr_rd", rdata, 16'h1234);

    // Full-rate churn: three frees then five allocs per 8 cycles.
    live_q = '{16'h5000, 16'h5001, 16'h5002, 16'h5003};
    exp_q.delete();
    model_top = 4;
    for (int c = 0; c < 256; c++) begin
      if ((c % 8) < 3) begin
        int k;
        logic [15:0] victim;
        k = $urandom_range(0, live_q.size() - 1);
        victim = live_q[k];
        live_q.delete(k);
        exp_q.push_back(victim);
        do_free(victim);
        check("churn_free_aaddr", aaddr, UNDEF);
      end else begin
        logic [15:0] exp_addr;
        int dup;
        if (exp_q.size() > 0) exp_addr = exp_q.pop_back();
        else begin
          exp_addr = 16'h5000 | 16'(model_top);
          model_top++;
        end
        do_alloc(16'(c));
        check("churn_alloc", aaddr, exp_addr);
        dup = 0;
        foreach (live_q[j]) if (live_q[j] == aaddr) dup = 1;
        check("churn_unique", dup, 0);
        live_q.push_back(exp_addr);
      end
      check("churn_fcnt", free_cnt, exp_q.size());
    end
    check("churn_err", err, 0);
    check("churn_top", top, model_top);

    // Double free: bitmap catches the second one; error is sticky.
    begin
      logic [15:0] victim;
      victim = live_q[0];
      do_free(victim); check("df_first_ok", err, 0);
      do_free(victim); check("df_err", err, 1); check("df_code", err_code, 4);
      do_read(16'h6000); check("df_sticky_code", err_code, 4);
      check("df_rdata_undef", rdata, UNDEF);
      do_alloc(16'h7777); check("df_aaddr_undef", aaddr, UNDEF);
    end

    // Out-of-range read.
    main_reset();
    do_alloc(16'h1111); check("rr_al", aaddr, 16'h5000);
    do_read(16'h6000); check("range_err", err, 1); check("range_code", err_code, 3);

    // Port conflict.
    main_reset();
    do_alloc(16'h2222); check("pc_al", aaddr, 16'h5000);
    op(1, 16'h3333, 0, 0, 0, 0, 0, 1, 16'h5000);
    check("conf_err", err, 1); check("conf_code", err_code, 1);
    check("conf_aaddr", aaddr, UNDEF);
    check("conf_top", top, 1);

    // Small heap: fill, overflow, then recover through reset.
    s_rst = 1'b0;
    s_alloc(16'hC000); check("s_al0", s_aaddr, 16'h5000);
    s_alloc(16'hC001); check("s_al1", s_aaddr, 16'h5001);
    s_alloc(16'hC002); check("s_al2", s_aaddr, 16'h5002);
    s_alloc(16'hC003); check("s_al3", s_aaddr, 16'h5003);
    check("s_top_full", s_top, 4);
    s_alloc(16'hC004);
    check("s_oom_err", s_err, 1); check("s_oom_code", s_err_code, 2);
    check("s_oom_aaddr", s_aaddr, UNDEF);
    s_rd = 1; s_raddr = 16'h5000;
    @(posedge clk); #1;
    s_rd = 0;
    check("s_rd_undef", s_rdata, UNDEF);
    s_rst = 1'b1;
    #1;
    check("s_rst_err", s_err, 0);
    check("s_rst_code", s_err_code, 0);
    check("s_rst_aaddr", s_aaddr, 16'h0000);
    check("s_rst_rdata", s_rdata, 16'h0000);
    check("s_rst_top", s_top, 0);
    check("s_rst_fcnt", s_free_cnt, 0);
    @(posedge clk); #1;
    s_rst = 1'b0;
    s_alloc(16'hD000); check("s_resume", s_aaddr, 16'h5000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
